// File: rtl/dac_frame_ctrl.sv
// dac_frame_ctrl: ramp sample and slot counter feeder for the DAC serializer.
// Define RAMP_TRI_EN to add the triangle waveform and its direction register.
module dac_frame_ctrl #(
   parameter int FRAME_LEN = 20,
   parameter logic [5:0] IDLE_CNT = 6'd63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        mode,
   input  logic [15:0] ramp_min,
   input  logic [15:0] ramp_max,
   input  logic [15:0] ramp_step,
   output logic [15:0] ramp_out,
   output logic [5:0]  delay_cnt,
   output logic        frame_done,
   output logic        busy
);
   localparam logic [5:0] LAST = 6'(FRAME_LEN - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [15:0] s_min, s_max, s_step, next;
   logic [16:0] sum;
   logic degen;
   assign sum = {1'b0, ramp_out} + {1'b0, s_step};
   assign degen = s_min >= s_max;
`ifdef RAMP_TRI_EN
   logic s_mode, dir, dir_next, floor_hit;
   // dir = 1 means descending; the 17-bit compare covers both floor conditions
   assign floor_hit = {1'b0, ramp_out} <= {1'b0, s_min} + {1'b0, s_step};
   assign dir_next = !degen && s_mode && (dir ? !floor_hit : sum >= {1'b0, s_max});
   assign next = degen ? s_min
      : !s_mode ? (sum > {1'b0, s_max} ? s_min : sum[15:0])
      : dir ? (floor_hit ? s_min : ramp_out - s_step)
      : (dir_next ? s_max : sum[15:0]);
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign next = degen || sum > {1'b0, s_max} ? s_min : sum[15:0];
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         frame_done <= 1'b0;
         ramp_out <= '0;
         delay_cnt <= IDLE_CNT;
         s_min <= '0;
         s_max <= '0;
         s_step <= '0;
`ifdef RAMP_TRI_EN
         s_mode <= 1'b0;
         dir <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (state == IDLE) begin
            if (en) begin
               state <= RUN;
               busy <= 1'b1;
               delay_cnt <= '0;
               ramp_out <= ramp_min;
               s_min <= ramp_min;
               s_max <= ramp_max;
               s_step <= ramp_step;
`ifdef RAMP_TRI_EN
               s_mode <= mode;
               dir <= 1'b0;
`endif
            end
         end else if (delay_cnt == LAST) begin
            if (en) begin
               delay_cnt <= '0;
               ramp_out <= next;
               s_min <= ramp_min;
               s_max <= ramp_max;
               s_step <= ramp_step;
`ifdef RAMP_TRI_EN
               s_mode <= mode;
               dir <= dir_next;
`endif
            end else begin
               state <= IDLE;
               busy <= 1'b0;
               delay_cnt <= IDLE_CNT;
            end
         end else begin
            delay_cnt <= delay_cnt + 6'd1;
            frame_done <= delay_cnt + 6'd1 == LAST;
         end
      end
endmodule

// File: tb/tb_dac_frame_ctrl.sv
// tb_dac_frame_ctrl: directed and random frames checked against a frame-level ramp model.
module tb_dac_frame_ctrl;
   localparam int FL = 20;
   logic clk = 0, rst = 0, en = 0, mode = 0;
   logic [15:0] ramp_min = 0, ramp_max = 0, ramp_step = 0;
   logic [15:0] ramp_out;
   logic [5:0] delay_cnt;
   logic frame_done, busy;
   int errs = 0, checks = 0;
   int m_ramp, sh_min, sh_max, sh_step, sh_mode, m_dir;

   dac_frame_ctrl #(.FRAME_LEN(FL), .IDLE_CNT(6'd63)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .ramp_min(ramp_min), .ramp_max(ramp_max), .ramp_step(ramp_step),
      .ramp_out(ramp_out), .delay_cnt(delay_cnt), .frame_done(frame_done), .busy(busy));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic set_cfg(input int mn, input int mx, input int st, input bit md);
      ramp_min = 16'(mn);
      ramp_max = 16'(mx);
      ramp_step = 16'(st);
      mode = md;
   endtask

   function automatic void capture();
      sh_min = ramp_min;
      sh_max = ramp_max;
      sh_step = ramp_step;
`ifdef RAMP_TRI_EN
      sh_mode = mode;
`else
      sh_mode = 0;
`endif
   endfunction

   // Frame-level ramp rules in plain signed integer arithmetic.
   function automatic void advance();
      int s = m_ramp + sh_step;
      if (sh_min >= sh_max) begin
         m_ramp = sh_min;
         m_dir = 0;
      end else if (sh_mode == 0) m_ramp = (s > sh_max) ? sh_min : s;
      else if (m_dir == 0) begin
         if (s >= sh_max) begin
            m_ramp = sh_max;
            m_dir = 1;
         end else m_ramp = s;
      end else if (m_ramp - sh_step <= sh_min) begin
         m_ramp = sh_min;
         m_dir = 0;
      end else m_ramp = m_ramp - sh_step;
   endfunction

   task automatic start(input int mn, input int mx, input int st, input bit md);
      set_cfg(mn, mx, st, md);
      en = 1;
      tick();
      capture();
      m_ramp = mn;
      m_dir = 0;
   endtask

   // Checks one whole frame; at slot chg the inputs switch to the new config and en value.
   task automatic frame_run(input int chg, input int mn, input int mx, input int st, input bit md, input bit nen);
      for (int k = 0; k < FL; k++) begin
         chk("cnt", delay_cnt, k);
         chk("ramp_const", ramp_out, m_ramp);
         chk("frame_done", frame_done, k == FL - 1);
         chk("busy_run", busy, 1);
         if (k == chg) begin
            set_cfg(mn, mx, st, md);
            en = nen;
         end
         tick();
      end
      if (en) begin
         advance();
         capture();
      end else begin
         chk("stop_cnt", delay_cnt, 63);
         chk("stop_busy", busy, 0);
         chk("stop_done", frame_done, 0);
         chk("stop_ramp_hold", ramp_out, m_ramp);
      end
   endtask

   task automatic frame_keep();
      frame_run(-1, 0, 0, 0, 0, 1);
   endtask

   initial begin
      int saw[7] = '{0, 4, 8, 12, 16, 0, 4};
      #2 rst = 1;
      #1;
      chk("rst_cnt", delay_cnt, 63);
      chk("rst_ramp", ramp_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      tick();
      rst = 0;
      tick();
      chk("idle_cnt", delay_cnt, 63);

      start(0, 16, 4, 0);
      for (int i = 0; i < 7; i++) begin
         chk("saw_seq", ramp_out, saw[i]);
         frame_keep();
      end
      frame_run(5, 0, 16, 4, 0, 0);
      tick();
      chk("idle_hold_cnt", delay_cnt, 63);
      chk("idle_hold_ramp", ramp_out, m_ramp);

      start(7, 100, 4, 0);
      chk("restart_cnt", delay_cnt, 0);
      chk("restart_ramp", ramp_out, 7);
      frame_run(3, 0, 100, 4, 0, 0);

`ifdef RAMP_TRI_EN
      begin
         int tri_exp[8] = '{0, 4, 8, 10, 6, 2, 0, 4};
         start(0, 10, 4, 1);
         for (int i = 0; i < 8; i++) begin
            chk("tri_seq", ramp_out, tri_exp[i]);
            frame_keep();
         end
         frame_run(0, 0, 10, 4, 1, 0);
      end
`endif

      start(0, 100, 4, 0);
      frame_keep();
      frame_keep();
      chk("cfg_pre", ramp_out, 8);
      frame_run(10, 0, 100, 1, 0, 1);
      chk("cfg_old_step", ramp_out, 12);
      frame_keep();
      chk("cfg_new_step", ramp_out, 13);
      frame_run(0, 50, 20, 3, 0, 0);

      start(50, 20, 3, 0);
      for (int i = 0; i < 3; i++) begin
         chk("degen", ramp_out, 50);
         frame_keep();
      end
      frame_run(0, 0, 100, 0, 0, 0);
      start(0, 100, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("step0", ramp_out, 0);
         frame_keep();
      end

      for (int i = 0; i < 30; i++) begin
         int mn = $urandom_range(0, 40), mx = $urandom_range(0, 60), st = $urandom_range(0, 15);
         bit md = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            mn = $urandom_range(16'hFF00, 16'hFFFF);
            mx = $urandom_range(16'hFF00, 16'hFFFF);
            st = $urandom_range(0, 16'hFFFF);
         end
         if (!busy) start($urandom_range(0, 40), $urandom_range(0, 60), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
         frame_run($urandom_range(0, FL - 1), mn, mx, st, md, $urandom_range(0, 4) != 0);
      end

      if (!busy) start(3, 90, 5, 0);
      for (int k = 0; k < 7; k++) tick();
      chk("pre_rst_cnt", delay_cnt, 7);
      #2 rst = 1;
      #1;
      chk("mid_rst_cnt", delay_cnt, 63);
      chk("mid_rst_ramp", ramp_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", frame_done, 0);
      tick();
      rst = 0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/dac_frame_ctrl.md
Name: dac_frame_ctrl

Overview:
Upstream feeder for the DAC serializer stage. It generates the 16-bit ramp sample (`ramp_out`) and the per-bit frame counter (`delay_cnt`) that the serializer decodes into SYNC/DIN timing. The frame timing is fixed:
- slots 0–1: lead-in
- slots 2–17: data bits, MSB first
- slots 18 to FRAME_LEN-1: idle, with SYNC high

`ramp_out` only changes at frame boundaries, so every serialized word is coherent.

Parameters:
FRAME_LEN, 20, slots per frame. Legal range 19..63. Slots 18..FRAME_LEN-1 are idle.
IDLE_CNT, 6'd63, `delay_cnt` value driven while stopped. It must decode to SYNC high / DIN low downstream.

Ports:
clk  in  1  system clock; `dac_clk` is derived from it downstream
rst  in  1  asynchronous, active-high reset
en  in  1  run request; sampled only in IDLE and at the last slot of a frame
mode  in  1  0 = sawtooth, 1 = triangle (see Optional Feature)
ramp_min  in  16  lower ramp bound (unsigned)
ramp_max  in  16  upper ramp bound (unsigned)
ramp_step  in  16  increment per frame (unsigned)
ramp_out  out  16  current sample to serialize
delay_cnt  out  6  slot counter to serializer
frame_done  out  1  high while `delay_cnt` == FRAME_LEN-1
busy  out  1  high in RUN state

Behaviour:
- Reset (async) values:
  - state = IDLE
  - `ramp_out` = 16'h0000
  - `delay_cnt` = IDLE_CNT
  - `frame_done` = 0, `busy` = 0
  - direction = up
  - config shadow registers = 0
- All outputs are registered. Triangle direction is an internal register.
- **IDLE:**
  - `delay_cnt` holds IDLE_CNT.
  - On the edge where `en` = 1:
    - capture `ramp_min`/`ramp_max`/`ramp_step`/`mode` into the shadow registers
    - `ramp_out` <= `ramp_min`, direction <= up
    - `delay_cnt` <= 0, state <= RUN
  - First frame latency: `delay_cnt` = 0 one cycle after `en` is sampled high.
- **RUN:**
  - `delay_cnt` increments by 1 per clock.
  - `frame_done` is set on the edge that loads FRAME_LEN-1 and cleared on the next edge.
- **Frame end** (edge with `delay_cnt` == FRAME_LEN-1):
  - If `en` = 1:
    - `delay_cnt` <= 0
    - `ramp_out` <= next sample, computed from the shadow config
    - then re-capture the shadow config from the inputs; new config applies from the following frame end
  - If `en` = 0:
    - `delay_cnt` <= IDLE_CNT, state <= IDLE
    - `ramp_out` holds
  - Dropping `en` mid-frame never truncates a frame.
- **Next-sample arithmetic:** 17-bit unsigned, no overflow wrap.
  - Sawtooth:
    - sum = `ramp_out` + step
    - if sum > max: next = min; else next = sum
  - Triangle, direction up:
    - sum = `ramp_out` + step
    - if sum >= max: next = max, direction <= down; else next = sum
  - Triangle, direction down:
    - if `ramp_out` < min + step, or `ramp_out` − step <= min: next = min, direction <= up
    - else next = `ramp_out` − step
- **Boundary conditions:**
  - step = 0: sample holds at its current value.
  - min >= max (shadow): next = min in every mode; direction forced up.
  - Config inputs changing mid-frame have no effect until the frame end.
  - `ramp_out` is constant across `delay_cnt` 0..FRAME_LEN-1 of any frame.
  - rst asserted mid-frame: immediate return to reset values. `delay_cnt` = IDLE_CNT forces SYNC high downstream, so the partial word is aborted by the DAC.

Optional Feature:
Macro RAMP_TRI_EN.
- Defined: the triangle datapath and direction register are present; `mode` selects sawtooth or triangle.
- Undefined: `mode` is ignored (port retained, unused); sawtooth only; no direction register is synthesized.

Test Plan:
1. Reset: assert rst mid-frame at `delay_cnt` = 7 -> same cycle `delay_cnt` = 63, `ramp_out` = 0, `busy` = 0, `frame_done` = 0.
2. Sawtooth: min = 0, max = 16, step = 4, `en` held high -> `ramp_out` per frame 0, 4, 8, 12, 16, 0, 4. Each frame is exactly 20 cycles with `delay_cnt` 0..19. `frame_done` is high only at slot 19.
3. Triangle (RAMP_TRI_EN defined), mode = 1: min = 0, max = 10, step = 4 -> 0, 4, 8, 10, 6, 2, 0, 4.
4. Stop: drop `en` at `delay_cnt` = 5 -> frame runs through slot 19, then `delay_cnt` = 63 and `busy` = 0. `ramp_out` holds its last value. Re-assert `en` -> `ramp_out` = `ramp_min`, `delay_cnt` = 0 one cycle later.
5. Config timing: change step 4 -> 1 at slot 10 of a frame whose sample is 8 (min = 0, max = 100). Next frame = 12 (old shadow step); the frame after = 13.
6. Degenerate config: min = 50, max = 20, step = 3 -> `ramp_out` = 50 every frame. Separately, step = 0 with min = 0 -> `ramp_out` stays 0.
